// File: rtl/vcm_hill_climb_if.sv
// Bus between the autofocus sweep controller and its surroundings:
// key/frame/sharpness inputs from the statistics side, VCM code and
// status outputs toward the I2C writer and the video overlay.
interface vcm_hill_climb_if #(
    parameter int SHARP_W = 24
);
    logic               AUTO_FOC;
    logic               FRAME_END;
    logic [SHARP_W-1:0] SHARP;
    logic               SHARP_VALID;
    logic [9:0]         STEP;
    logic [15:0]        VCM_DATA;
    logic [9:0]         BEST_STEP;
    logic               VCM_END;
    logic               BUSY;

    // Environment side: drives key, frame and sharpness, observes the lens code.
    modport master (
        output AUTO_FOC, FRAME_END, SHARP, SHARP_VALID,
        input  STEP, VCM_DATA, BEST_STEP, VCM_END, BUSY
    );

    // Controller side.
    modport slave (
        input  AUTO_FOC, FRAME_END, SHARP, SHARP_VALID,
        output STEP, VCM_DATA, BEST_STEP, VCM_END, BUSY
    );
endinterface

// File: rtl/vcm_hill_climb.sv
// Autofocus hill-climb sweep controller for the lens voice-coil motor.
// Steps the VCM code across its range, waits for the lens to settle after
// every move, records the code of the sharpest frame and parks the lens there.
// Optional feature: define VCM_HILL_EARLY_STOP_EN to abort the sweep after two
// consecutive measurements below half of the best sharpness seen so far.
module vcm_hill_climb #(
    parameter int         SHARP_W       = 24,
    parameter int         STEP_INC      = 16,
    parameter int         STEP_MAX      = 1023,
    parameter int         SETTLE_FRAMES = 2,
    parameter logic [3:0] VCM_S         = 4'h0
) (
    input  logic             VIDEO_CLK,
    input  logic             RESET,
    vcm_hill_climb_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_RETURN  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Sweep arithmetic is done one bit wider than the code so the end test never wraps.
    localparam logic [10:0] INC_C    = 11'(STEP_INC);
    localparam logic [10:0] MAX_C    = 11'(STEP_MAX);
    localparam logic [3:0]  SETTLE_C = 4'(SETTLE_FRAMES);

    logic [2:0]         state_q,      state_d;
    logic [9:0]         step_q,       step_d;
    logic [9:0]         best_step_q,  best_step_d;
    logic [SHARP_W-1:0] best_sharp_q, best_sharp_d;
    logic [3:0]         settle_cnt_q, settle_cnt_d;
    logic               vcm_end_q,    vcm_end_d;
    logic               busy_q,       busy_d;
    logic               auto_foc_q;
    logic               start_s;
    logic [10:0]        step_sum_s;
    logic               early_stop_s;
`ifdef VCM_HILL_EARLY_STOP_EN
    logic [1:0]         drop_cnt_q,   drop_cnt_d;
`endif

    // Falling edge of the active-low key, against the previous sampled level.
    assign start_s    = auto_foc_q & ~bus.AUTO_FOC;
    assign step_sum_s = {1'b0, step_q} + INC_C;

    // Next-state logic for the sweep sequencer and its datapath registers.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        best_step_d  = best_step_q;
        best_sharp_d = best_sharp_q;
        settle_cnt_d = settle_cnt_q;
        vcm_end_d    = vcm_end_q;
        busy_d       = busy_q;
        early_stop_s = 1'b0;
`ifdef VCM_HILL_EARLY_STOP_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_s) begin
                    step_d       = 10'd0;
                    best_step_d  = 10'd0;
                    best_sharp_d = '0;
                    settle_cnt_d = 4'd0;
                    vcm_end_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_SETTLE;
`ifdef VCM_HILL_EARLY_STOP_EN
                    drop_cnt_d   = 2'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_SETTLE: begin
                if (bus.FRAME_END) begin
                    if (settle_cnt_q == (SETTLE_C - 4'd1)) begin
                        settle_cnt_d = 4'd0;
                        state_d      = S_MEASURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q;
                end
            end
            S_MEASURE: begin
                // Frame ends are deliberately not counted here, even when coincident.
                if (bus.SHARP_VALID) begin
                    // Strict compare: on ties the earlier (lower) code is kept.
                    if (bus.SHARP > best_sharp_q) begin
                        best_sharp_d = bus.SHARP;
                        best_step_d  = step_q;
                    end else begin
                        best_sharp_d = best_sharp_q;
                    end
`ifdef VCM_HILL_EARLY_STOP_EN
                    if (bus.SHARP < (best_sharp_q >> 1)) begin
                        drop_cnt_d = drop_cnt_q + 2'd1;
                    end else begin
                        drop_cnt_d = 2'd0;
                    end
                    early_stop_s = (drop_cnt_d == 2'd2);
`endif
                    settle_cnt_d = 4'd0;
                    // The lens goes straight back to the best code, including this frame's result.
                    if ((step_sum_s > MAX_C) || early_stop_s) begin
                        step_d  = best_step_d;
                        state_d = S_RETURN;
                    end else begin
                        step_d  = step_sum_s[9:0];
                        state_d = S_SETTLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_RETURN: begin
                if (bus.FRAME_END) begin
                    if (settle_cnt_q == (SETTLE_C - 4'd1)) begin
                        settle_cnt_d = 4'd0;
                        vcm_end_d    = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q;
                end
            end
            default: begin
                step_d       = 10'd0;
                best_step_d  = 10'd0;
                best_sharp_d = '0;
                settle_cnt_d = 4'd0;
                vcm_end_d    = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State, datapath and key-edge registers with synchronous reset.
    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            step_q       <= 10'd0;
            best_step_q  <= 10'd0;
            best_sharp_q <= '0;
            settle_cnt_q <= 4'd0;
            vcm_end_q    <= 1'b1;
            busy_q       <= 1'b0;
            auto_foc_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            best_step_q  <= best_step_d;
            best_sharp_q <= best_sharp_d;
            settle_cnt_q <= settle_cnt_d;
            vcm_end_q    <= vcm_end_d;
            busy_q       <= busy_d;
            auto_foc_q   <= bus.AUTO_FOC;
        end
    end

`ifdef VCM_HILL_EARLY_STOP_EN
    // Consecutive-drop counter for the early abort.
    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            drop_cnt_q <= 2'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

    // VCM word is built from the code register so both always agree.
    assign bus.STEP      = step_q;
    assign bus.VCM_DATA  = {2'b00, step_q, VCM_S};
    assign bus.BEST_STEP = best_step_q;
    assign bus.VCM_END   = vcm_end_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_vcm_hill_climb.sv
// Directed bench for vcm_hill_climb: STEP_INC=256, SETTLE_FRAMES=2 gives
// sweep codes 0,256,512,768. With VCM_HILL_EARLY_STOP_EN defined a second
// instance with STEP_INC=128 exercises the early abort.
module tb_vcm_hill_climb;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    vcm_hill_climb_if #(.SHARP_W(24)) bus ();

    vcm_hill_climb #(
        .SHARP_W(24), .STEP_INC(256), .STEP_MAX(1023),
        .SETTLE_FRAMES(2), .VCM_S(4'h0)
    ) dut (
        .VIDEO_CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

`ifdef VCM_HILL_EARLY_STOP_EN
    vcm_hill_climb_if #(.SHARP_W(24)) es_bus ();
    logic [9:0] es_max;

    assign es_bus.AUTO_FOC    = bus.AUTO_FOC;
    assign es_bus.FRAME_END   = bus.FRAME_END;
    assign es_bus.SHARP       = bus.SHARP;
    assign es_bus.SHARP_VALID = bus.SHARP_VALID;

    vcm_hill_climb #(
        .SHARP_W(24), .STEP_INC(128), .STEP_MAX(1023),
        .SETTLE_FRAMES(2), .VCM_S(4'h0)
    ) dut_es (
        .VIDEO_CLK(clk),
        .RESET(rst),
        .bus(es_bus)
    );

    always @(posedge clk) begin
        if (rst) es_max <= 10'd0;
        else if (es_bus.STEP > es_max) es_max <= es_bus.STEP;
    end
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        bus.FRAME_END = 1'b1;
        tick();
        bus.FRAME_END = 1'b0;
        tick();
    endtask

    task automatic measure(input logic [23:0] v, input logic with_fe);
        bus.SHARP       = v;
        bus.SHARP_VALID = 1'b1;
        bus.FRAME_END   = with_fe;
        tick();
        bus.SHARP_VALID = 1'b0;
        bus.FRAME_END   = 1'b0;
        tick();
    endtask

    task automatic start_pulse();
        bus.AUTO_FOC = 1'b0;
        tick();
        bus.AUTO_FOC = 1'b1;
        tick();
    endtask

    task automatic point(input logic [23:0] v);
        frame();
        frame();
        measure(v, 1'b0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        bus.AUTO_FOC    = 1'b1;
        bus.FRAME_END   = 1'b0;
        bus.SHARP       = 24'd0;
        bus.SHARP_VALID = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state, then held across three frames with no start.
        check("rst_step", bus.STEP, 10'd0);
        check("rst_vcm_data", bus.VCM_DATA, 16'h0000);
        check("rst_vcm_end", bus.VCM_END, 1'b1);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_best", bus.BEST_STEP, 10'd0);
        frame();
        frame();
        frame();
        check("idle_step", bus.STEP, 10'd0);
        check("idle_vcm_end", bus.VCM_END, 1'b1);

        // Basic sweep: 10,50,30,20 at codes 0,256,512,768.
        bus.AUTO_FOC = 1'b0;
        tick();
        bus.AUTO_FOC = 1'b1;
        check("start_vcm_end", bus.VCM_END, 1'b0);
        check("start_busy", bus.BUSY, 1'b1);
        tick();
        point(24'd10);
        check("p0_step", bus.STEP, 10'd256);
        check("p0_best", bus.BEST_STEP, 10'd0);
        // Sharpness strobe while settling must be ignored.
        measure(24'd999, 1'b0);
        check("settle_gate_best", bus.BEST_STEP, 10'd0);
        check("settle_gate_step", bus.STEP, 10'd256);
        point(24'd50);
        check("p1_step", bus.STEP, 10'd512);
        check("p1_best", bus.BEST_STEP, 10'd256);
        // Key pressed mid-sweep does not restart.
        start_pulse();
        check("midstart_step", bus.STEP, 10'd512);
        check("midstart_vcm_end", bus.VCM_END, 1'b0);
        point(24'd30);
        check("p2_step", bus.STEP, 10'd768);
        point(24'd20);
        check("ret_step", bus.STEP, 10'd256);
        check("ret_best", bus.BEST_STEP, 10'd256);
        check("ret_vcm_end", bus.VCM_END, 1'b0);
        frame();
        check("ret1_vcm_end", bus.VCM_END, 1'b0);
        bus.FRAME_END = 1'b1;
        tick();
        bus.FRAME_END = 1'b0;
        check("done_vcm_end", bus.VCM_END, 1'b1);
        check("done_busy", bus.BUSY, 1'b0);
        check("done_step", bus.STEP, 10'd256);
        check("done_vcm_data", bus.VCM_DATA, 16'h1000);
        tick();

        // Restart from DONE, then a sweep of equal sharpness values.
        bus.AUTO_FOC = 1'b0;
        tick();
        bus.AUTO_FOC = 1'b1;
        check("restart_step", bus.STEP, 10'd0);
        check("restart_vcm_end", bus.VCM_END, 1'b0);
        check("restart_best", bus.BEST_STEP, 10'd0);
        tick();
        frame();
        frame();
        // Coincident frame end is not counted toward the next settle.
        measure(24'd40, 1'b1);
        check("tie0_step", bus.STEP, 10'd256);
        frame();
        measure(24'd99, 1'b0);
        check("coinc_best", bus.BEST_STEP, 10'd0);
        check("coinc_step", bus.STEP, 10'd256);
        frame();
        measure(24'd40, 1'b0);
        point(24'd40);
        point(24'd40);
        check("tie_best", bus.BEST_STEP, 10'd0);
        check("tie_ret_step", bus.STEP, 10'd0);
        frame();
        frame();
        check("tie_done", bus.VCM_END, 1'b1);

        // Reset in SETTLE at code 512.
        start_pulse();
        point(24'd5);
        point(24'd9);
        check("pre_rst_step", bus.STEP, 10'd512);
        frame();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_step", bus.STEP, 10'd0);
        check("midrst_best", bus.BEST_STEP, 10'd0);
        check("midrst_vcm_end", bus.VCM_END, 1'b1);
        check("midrst_busy", bus.BUSY, 1'b0);
        // IDLE after reset: frames alone do not start anything.
        frame();
        frame();
        measure(24'd77, 1'b0);
        check("postrst_best", bus.BEST_STEP, 10'd0);

`ifdef VCM_HILL_EARLY_STOP_EN
        // Early stop: 100,200,90,80 at codes 0,128,256,384.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        start_pulse();
        point(24'd100);
        point(24'd200);
        point(24'd90);
        point(24'd80);
        check("es_step", es_bus.STEP, 10'd128);
        check("es_vcm_end", es_bus.VCM_END, 1'b0);
        check("es_max_code", {22'd0, es_max}, 32'd384);
        frame();
        frame();
        check("es_done", es_bus.VCM_END, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
